// File: rtl/axi4_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_slave_regfile
//  Description : AXI4-Lite responder holding a bank of NUM_REGS 32-bit
//                control/status registers. The write (AW/W/B) and read (AR/R)
//                engines are independent. Byte strobes are honoured, and an
//                out-of-range index returns SLVERR. Register contents are
//                exported to the fabric, with a one-cycle pulse per write.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_regfile #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic [32*NUM_REGS-1:0]   REG_OUT,
    output logic [NUM_REGS-1:0]      WR_PULSE
);

    localparam int              IDX_W      = ADDR_WIDTH - 2;
    localparam logic [IDX_W:0]  c_NUM_REGS = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]      c_OKAY     = 2'b00;
    localparam logic [1:0]      c_SLVERR   = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_WAIT_W = 2'd1,
        WR_WAIT_A = 2'd2,
        WR_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    wr_state_t                  wr_state_q, wr_state_d;
    rd_state_t                  rd_state_q, rd_state_d;
    logic                       rdy_en_q;
    logic [IDX_W-1:0]           awidx_q;
    logic [31:0]                wdata_q;
    logic [3:0]                 wstrb_q;
    logic [32*NUM_REGS-1:0]     regs_q;
    logic [NUM_REGS-1:0]        wr_pulse_q;
    logic [1:0]                 bresp_q;
    logic [31:0]                rdata_q;
    logic [1:0]                 rresp_q;

    logic                       w_awready, w_wready, w_arready;
    logic                       w_aw_hs, w_w_hs, w_ar_hs;
    logic                       w_commit, w_lat_aw, w_lat_w;
    logic [IDX_W-1:0]           w_cm_idx;
    logic [31:0]                w_cm_data;
    logic [3:0]                 w_cm_strb;
    logic                       w_cm_ok;
    logic [NUM_REGS-1:0]        w_wr_sel;
    logic [IDX_W-1:0]           w_rd_idx;
    logic                       w_rd_ok;
    logic [31:0]                w_rd_data;
    logic                       w_unused_addr_lsbs;

    // Byte offset within a register is irrelevant: only word indices decode.
    assign w_unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    // Readies are gated by rdy_en_q so they stay low for one edge after reset.
    assign w_awready = rdy_en_q & ((wr_state_q == WR_IDLE) | (wr_state_q == WR_WAIT_A));
    assign w_wready  = rdy_en_q & ((wr_state_q == WR_IDLE) | (wr_state_q == WR_WAIT_W));
    assign w_arready = rdy_en_q & (rd_state_q == RD_IDLE);
    assign w_aw_hs   = AWVALID & w_awready;
    assign w_w_hs    = WVALID  & w_wready;
    assign w_ar_hs   = ARVALID & w_arready;

    // Write engine state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) wr_state_q <= WR_IDLE;
        else          wr_state_q <= wr_state_d;
    end

    // Write engine next state. It also selects the address, data and strobe
    // sources for the commit, which fires on the edge that enters WR_RESP.
    always_comb begin
        wr_state_d = wr_state_q;
        w_commit   = 1'b0;
        w_lat_aw   = 1'b0;
        w_lat_w    = 1'b0;
        w_cm_idx   = awidx_q;
        w_cm_data  = wdata_q;
        w_cm_strb  = wstrb_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    wr_state_d = WR_RESP;
                    w_commit   = 1'b1;
                    w_cm_idx   = AWADDR[ADDR_WIDTH-1:2];
                    w_cm_data  = WDATA;
                    w_cm_strb  = WSTRB;
                end else if (w_aw_hs) begin
                    wr_state_d = WR_WAIT_W;
                    w_lat_aw   = 1'b1;
                end else if (w_w_hs) begin
                    wr_state_d = WR_WAIT_A;
                    w_lat_w    = 1'b1;
                end
            end
            WR_WAIT_W: begin
                if (w_w_hs) begin
                    wr_state_d = WR_RESP;
                    w_commit   = 1'b1;
                    w_cm_data  = WDATA;
                    w_cm_strb  = WSTRB;
                end
            end
            WR_WAIT_A: begin
                if (w_aw_hs) begin
                    wr_state_d = WR_RESP;
                    w_commit   = 1'b1;
                    w_cm_idx   = AWADDR[ADDR_WIDTH-1:2];
                end
            end
            WR_RESP: begin
                if (BREADY) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    assign w_cm_ok = ({1'b0, w_cm_idx} < c_NUM_REGS);

    // One-hot select of the register being committed. It stays zero for an
    // out-of-range index because no slot matches.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_wr_dec
            assign w_wr_sel[i] = w_commit & (w_cm_idx == IDX_W'(i));
        end
    endgenerate

    // Ready enable, address/data holding registers, write pulse and write response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdy_en_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= '0;
            bresp_q    <= c_OKAY;
        end else begin
            rdy_en_q   <= 1'b1;
            wr_pulse_q <= w_wr_sel;
            if (w_lat_aw) awidx_q <= AWADDR[ADDR_WIDTH-1:2];
            if (w_lat_w) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (w_commit) bresp_q <= w_cm_ok ? c_OKAY : c_SLVERR;
        end
    end

    // Register bank: byte-lane update of the selected register on commit.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            regs_q <= {NUM_REGS{RESET_VALUE}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wr_sel[i] && w_cm_strb[b])
                        regs_q[32*i + 8*b +: 8] <= w_cm_data[8*b +: 8];
                end
            end
        end
    end

    // Read engine state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rd_state_q <= RD_IDLE;
        else          rd_state_q <= rd_state_d;
    end

    // Read engine next state.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (w_ar_hs) rd_state_d = RD_RESP;
            RD_RESP: if (RREADY)  rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign w_rd_idx = ARADDR[ADDR_WIDTH-1:2];
    assign w_rd_ok  = ({1'b0, w_rd_idx} < c_NUM_REGS);

    // Read mux. It samples the pre-edge register contents, so a read that
    // coincides with a commit to the same register returns the old value.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == IDX_W'(i)) w_rd_data = regs_q[32*i +: 32];
        end
    end

    // Read data/response capture on AR handshake; held until the R handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdata_q <= '0;
            rresp_q <= c_OKAY;
        end else if (w_ar_hs) begin
            rdata_q <= w_rd_ok ? w_rd_data : 32'h0;
            rresp_q <= w_rd_ok ? c_OKAY : c_SLVERR;
        end
    end

    assign AWREADY  = w_awready;
    assign WREADY   = w_wready;
    assign ARREADY  = w_arready;
    assign BVALID   = (wr_state_q == WR_RESP);
    assign BRESP    = bresp_q;
    assign RVALID   = (rd_state_q == RD_RESP);
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign REG_OUT  = regs_q;
    assign WR_PULSE = wr_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_slave_regfile
//  Description : Self-checking bench for axi4_lite_slave_regfile, compared
//                against an array-based register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave_regfile;

    logic         clk;
    logic         ARESETn;
    logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic         ARVALID, ARREADY, RVALID, RREADY;
    logic [11:0]  AWADDR, ARADDR;
    logic [31:0]  WDATA, RDATA;
    logic [3:0]   WSTRB;
    logic [1:0]   BRESP, RRESP;
    logic [511:0] REG_OUT;
    logic [15:0]  WR_PULSE;

    int           n_checks;
    int           n_errors;
    logic [31:0]  model [16];

    axi4_lite_slave_regfile #(
        .ADDR_WIDTH (12),
        .NUM_REGS   (16),
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .ACLK    (clk),
        .ARESETn (ARESETn),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .REG_OUT (REG_OUT),
        .WR_PULSE(WR_PULSE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [511:0] model_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic model_write(input logic [11:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp,
                               output logic [15:0] pulse);
        int idx;
        idx = int'(addr[11:2]);
        if (idx < 16) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            resp  = 2'b00;
            pulse = 16'd1 << idx;
        end else begin
            resp  = 2'b10;
            pulse = 16'h0;
        end
    endtask

    task automatic model_read(input logic [11:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr[11:2]);
        if (idx < 16) begin
            data = model[idx];
            resp = 2'b00;
        end else begin
            data = 32'h0;
            resp = 2'b10;
        end
    endtask

    // ---------------- bus drivers (no checking) ----------------
    task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_start, input int w_start,
                            input int b_delay, output logic [1:0] resp,
                            output logic bvalid_seen, output logic [15:0] pulse,
                            output logic [15:0] pulse_next, output logic [511:0] regs_seen,
                            output logic stall_ok, output logic timeout);
        int   c;
        logic aw_done, w_done, aw_fire, w_fire;
        c = 0; aw_done = 1'b0; w_done = 1'b0; timeout = 1'b0; stall_ok = 1'b1;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            AWVALID = !aw_done && (c >= aw_start);
            WVALID  = !w_done  && (c >= w_start);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            if (c > 60) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            if (aw_fire) aw_done = 1'b1;
            if (w_fire)  w_done  = 1'b1;
            c++;
        end
        if (!timeout) @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0;
        bvalid_seen = BVALID; resp = BRESP; pulse = WR_PULSE; regs_seen = REG_OUT;
        pulse_next = 16'h0;
        for (int k = 0; k < b_delay; k++) begin
            BREADY = 1'b0;
            @(negedge clk);
            if (k == 0) pulse_next = WR_PULSE;
            if (BVALID !== 1'b1 || BRESP !== resp || AWREADY !== 1'b0 || WREADY !== 1'b0)
                stall_ok = 1'b0;
        end
        BREADY = 1'b1;
        @(negedge clk);
        if (b_delay == 0) pulse_next = WR_PULSE;
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] addr, input int r_delay,
                           output logic [31:0] data, output logic [1:0] resp,
                           output logic rvalid_seen, output logic stall_ok,
                           output logic timeout);
        int   c;
        logic fire;
        c = 0; fire = 1'b0; timeout = 1'b0; stall_ok = 1'b1;
        ARADDR = addr;
        while (!fire) begin
            @(negedge clk);
            ARVALID = 1'b1;
            if (c > 60) begin
                timeout = 1'b1;
                break;
            end
            fire = ARREADY;
            @(posedge clk);
            c++;
        end
        if (!timeout) @(negedge clk);
        ARVALID = 1'b0;
        rvalid_seen = RVALID; data = RDATA; resp = RRESP;
        for (int k = 0; k < r_delay; k++) begin
            RREADY = 1'b0;
            @(negedge clk);
            if (RVALID !== 1'b1 || RDATA !== data || RRESP !== resp || ARREADY !== 1'b0)
                stall_ok = 1'b0;
        end
        RREADY = 1'b1;
        @(negedge clk);
        RREADY = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_handshake: got %b expected 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        n_checks++;
        if (REG_OUT !== model_vec() || WR_PULSE !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_regs: got %h pulse %h expected %h pulse 0", REG_OUT, WR_PULSE, model_vec());
        end
        n_checks++;
        if (BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_resp: got bresp %b rresp %b rdata %h expected 0", BRESP, RRESP, RDATA);
        end
        ARESETn = 1'b1;
        #1;
        n_checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_rdy_delay: got %b expected 000", {AWREADY, WREADY, ARREADY});
        end
        @(negedge clk);
        n_checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_errors++;
            $display("FAIL reset_rdy_on: got %b expected 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_write_same_cycle();
        logic [1:0] resp, eresp; logic bv, st, to; logic [15:0] p, pn, ep; logic [511:0] rs;
        do_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, bv, p, pn, rs, st, to);
        model_write(12'h008, 32'hDEADBEEF, 4'hF, eresp, ep);
        n_checks++;
        if (to || bv !== 1'b1 || resp !== eresp) begin
            n_errors++;
            $display("FAIL wr_same_resp: got bvalid %b bresp %b timeout %b expected 1 %b 0", bv, resp, to, eresp);
        end
        n_checks++;
        if (rs !== model_vec() || p !== ep) begin
            n_errors++;
            $display("FAIL wr_same_data: got reg2 %h pulse %h expected %h pulse %h", rs[95:64], p, model[2], ep);
        end
        n_checks++;
        if (pn !== 16'h0) begin
            n_errors++;
            $display("FAIL wr_same_pulse_width: got %h expected 0000", pn);
        end
    endtask

    task automatic test_w_first_stall();
        logic [1:0] resp, eresp; logic bv, st, to; logic [15:0] p, pn, ep; logic [511:0] rs;
        do_write(12'h008, 32'h000000AA, 4'b0001, 3, 0, 5, resp, bv, p, pn, rs, st, to);
        model_write(12'h008, 32'h000000AA, 4'b0001, eresp, ep);
        n_checks++;
        if (to || rs[95:64] !== 32'hDEADBEAA || rs !== model_vec() || p !== ep || resp !== eresp) begin
            n_errors++;
            $display("FAIL wr_wfirst: got reg2 %h pulse %h bresp %b expected DEADBEAA pulse %h bresp %b", rs[95:64], p, resp, ep, eresp);
        end
        n_checks++;
        if (st !== 1'b1) begin
            n_errors++;
            $display("FAIL wr_b_stall: got stable %b expected 1", st);
        end
        n_checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b110) begin
            n_errors++;
            $display("FAIL wr_back_to_back: got aw/w/b %b expected 110", {AWREADY, WREADY, BVALID});
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] d, ed; logic [1:0] r, er; logic rv, st, to;
        do_read(12'h008, 3, d, r, rv, st, to);
        model_read(12'h008, ed, er);
        n_checks++;
        if (to || rv !== 1'b1 || d !== ed || r !== er) begin
            n_errors++;
            $display("FAIL rd_stall_data: got rvalid %b rdata %h rresp %b expected 1 %h %b", rv, d, r, ed, er);
        end
        n_checks++;
        if (st !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_stall_stable: got %b expected 1", st);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] resp, eresp; logic bv, st, to; logic [15:0] p, pn, ep; logic [511:0] rs;
        logic [31:0] d, ed; logic [1:0] r, er; logic rv;
        do_write(12'h040, 32'h55AA55AA, 4'hF, 0, 1, 1, resp, bv, p, pn, rs, st, to);
        model_write(12'h040, 32'h55AA55AA, 4'hF, eresp, ep);
        n_checks++;
        if (to || resp !== 2'b10 || resp !== eresp || p !== 16'h0 || rs !== model_vec()) begin
            n_errors++;
            $display("FAIL wr_slverr: got bresp %b pulse %h expected 10 pulse 0000 regs unchanged", resp, p);
        end
        do_read(12'h043, 0, d, r, rv, st, to);
        model_read(12'h043, ed, er);
        n_checks++;
        if (to || d !== ed || r !== er || r !== 2'b10) begin
            n_errors++;
            $display("FAIL rd_slverr: got rdata %h rresp %b expected %h %b", d, r, ed, er);
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp, eresp; logic bv, st, to; logic [15:0] p, pn, ep; logic [511:0] rs;
        logic [31:0] d, ed, old; logic [1:0] r, er; logic rv;
        do_write(12'h004, 32'hCAFEF00D, 4'hF, 0, 0, 0, resp, bv, p, pn, rs, st, to);
        model_write(12'h004, 32'hCAFEF00D, 4'hF, eresp, ep);
        old = model[1];
        @(negedge clk);
        AWADDR = 12'h004; WDATA = 32'h12345678; WSTRB = 4'hF;
        ARADDR = 12'h004;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        n_checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_errors++;
            $display("FAIL coll_ready: got %b expected 111", {AWREADY, WREADY, ARREADY});
        end
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        model_write(12'h004, 32'h12345678, 4'hF, eresp, ep);
        n_checks++;
        if (RVALID !== 1'b1 || RDATA !== old) begin
            n_errors++;
            $display("FAIL coll_old_value: got rvalid %b rdata %h expected 1 %h", RVALID, RDATA, old);
        end
        n_checks++;
        if (BVALID !== 1'b1 || REG_OUT !== model_vec() || WR_PULSE !== ep) begin
            n_errors++;
            $display("FAIL coll_commit: got bvalid %b reg1 %h pulse %h expected 1 %h %h", BVALID, REG_OUT[63:32], WR_PULSE, model[1], ep);
        end
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0; RREADY = 1'b0;
        do_read(12'h004, 0, d, r, rv, st, to);
        model_read(12'h004, ed, er);
        n_checks++;
        if (to || d !== ed || r !== er) begin
            n_errors++;
            $display("FAIL coll_followup: got %h %b expected %h %b", d, r, ed, er);
        end
    endtask

    task automatic test_reset_midop();
        logic [1:0] eresp; logic [15:0] ep;
        @(negedge clk);
        AWADDR = 12'h00C; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        n_checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b010) begin
            n_errors++;
            $display("FAIL midop_wait_w: got aw/w/b %b expected 010", {AWREADY, WREADY, BVALID});
        end
        ARESETn = 1'b0;
        model_reset();
        @(negedge clk);
        ARESETn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (BVALID !== 1'b0 || REG_OUT !== model_vec() || {AWREADY, WREADY} !== 2'b11) begin
            n_errors++;
            $display("FAIL midop_reset: got bvalid %b aw/w %b reg3 %h expected 0 11 %h", BVALID, {AWREADY, WREADY}, REG_OUT[127:96], model[3]);
        end
        // The pre-reset address must have been discarded: W alone waits for AW.
        WDATA = 32'hA5A5_0F0F; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge clk);
        WVALID = 1'b0;
        n_checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b100) begin
            n_errors++;
            $display("FAIL midop_addr_dropped: got aw/w/b %b expected 100", {AWREADY, WREADY, BVALID});
        end
        AWADDR = 12'h00C; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        model_write(12'h00C, 32'hA5A5_0F0F, 4'hF, eresp, ep);
        n_checks++;
        if (BVALID !== 1'b1 || BRESP !== eresp || REG_OUT !== model_vec() || WR_PULSE !== ep) begin
            n_errors++;
            $display("FAIL midop_afirst_commit: got bvalid %b reg3 %h pulse %h expected 1 %h %h", BVALID, REG_OUT[127:96], WR_PULSE, model[3], ep);
        end
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] a; logic [31:0] dat, d, ed; logic [3:0] sb;
        logic [1:0] resp, eresp, r, er; logic bv, st, to, rv;
        logic [15:0] p, pn, ep; logic [511:0] rs;
        for (int it = 0; it < 60; it++) begin
            a   = (12'($urandom_range(0, 19)) << 2) | 12'($urandom_range(0, 3));
            dat = $urandom;
            sb  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, dat, sb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)), resp, bv, p, pn, rs, st, to);
                model_write(a, dat, sb, eresp, ep);
                n_checks++;
                if (to || bv !== 1'b1 || resp !== eresp || p !== ep || pn !== 16'h0 ||
                    rs !== model_vec() || st !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rand_write[%0d]: addr %h strb %h got bresp %b pulse %h/%h expected %b %h/0000", it, a, sb, resp, p, pn, eresp, ep);
                end
            end else begin
                do_read(a, int'($urandom_range(0, 2)), d, r, rv, st, to);
                model_read(a, ed, er);
                n_checks++;
                if (to || rv !== 1'b1 || d !== ed || r !== er || st !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rand_read[%0d]: addr %h got %h %b expected %h %b", it, a, d, r, ed, er);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        ARESETn = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        AWADDR = 12'h0; ARADDR = 12'h0; WDATA = 32'h0; WSTRB = 4'h0;
        model_reset();
        test_reset();
        test_write_same_cycle();
        test_w_first_stall();
        test_read_stall();
        test_slverr();
        test_collision();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
